// File: rtl/serial_sub_pkg.sv
// ============================================================================
// Module  : serial_sub_pkg
// Brief   : Shared FSM encoding and counter sizing for serial arithmetic blocks
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bit-position counter width; a 1-bit datapath still needs a 1-bit counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_sub_full_sub_cell.sv
// ============================================================================
// Module  : full_sub_cell
// Brief   : Combinational 1-bit full subtractor (d = a - b - bin)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module full_sub_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

`default_nettype wire

// File: rtl/serial_sub.sv
// ============================================================================
// Module  : serial_sub
// Brief   : Bit-serial N-bit subtractor with borrow behind valid/ready ports.
//           Optional signed-overflow output enabled by SERIAL_SUB_OVF_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] diff,
  output logic         bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int CW = cnt_width(N);

  state_t        state, state_nxt;
  logic [N-1:0]  a_sr, b_sr, a_nxt;
  logic [CW-1:0] cnt;
  logic          br, d, br_nxt, last;

  full_sub_cell u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (br),
    .d    (d),
    .bout (br_nxt)
  );

  assign last = (cnt == CW'(N - 1));

  // Result bits enter the minuend register from the MSB side as it drains.
  generate
    if (N == 1) begin : g_shift_n1
      assign a_nxt = d;
    end else begin : g_shift_nx
      assign a_nxt = {d, a_sr[N-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr <= '0;
      b_sr <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      diff <= '0;
      bout <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf  <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_sr <= a;
            b_sr <= b;
            br   <= bin;
            cnt  <= '0;
          end
        end
        ST_RUN: begin
          a_sr <= a_nxt;
          b_sr <= b_sr >> 1;
          br   <= br_nxt;
          cnt  <= cnt + 1'b1;
          if (last) begin
            diff <= a_nxt;
            bout <= br_nxt;
`ifdef SERIAL_SUB_OVF_EN
            // br is the borrow into the MSB on the final bit.
            ovf  <= br ^ br_nxt;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_sub.sv
// ============================================================================
// Module  : tb_serial_sub
// Brief   : Scoreboard bench for serial_sub (randomized + directed stimulus)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_sub;

  localparam int N = 8;

  typedef struct {
    logic [N-1:0] diff;
    logic         bout;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         bin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] diff;
  logic         bout;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   rnd = 1'b0;
  exp_t q[$];
  int   acc_q[$];

  serial_sub #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached (got timeout, need finish)");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the unsigned and signed views.
  function automatic exp_t model(input logic [N-1:0] av, input logic [N-1:0] bv, input logic bi);
    exp_t e;
    int   r, sr, lo, hi;
    r      = int'(av) - int'(bv) - int'(bi);
    e.diff = N'(r);
    e.bout = (r < 0);
    sr     = int'($signed(av)) - int'($signed(bv)) - int'(bi);
    lo     = -(2 ** (N - 1));
    hi     = (2 ** (N - 1)) - 1;
    e.ovf  = (sr < lo) || (sr > hi);
    return e;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [N-1:0] av, input logic [N-1:0] bv, input logic bi);
    bit done = 1'b0;
    in_valid = 1'b1;
    a = av;
    b = bv;
    bin = bi;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready && !rst) begin
        q.push_back(model(av, bv, bi));
        acc_q.push_back(cyc + 1);
        done = 1'b1;
      end
      @(posedge clk);
      #2;
      if (rnd) out_ready = 1'($urandom);
    end
    in_valid = 1'b0;
    chk("accept_timeout", 32'(done), 1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 100 && (q.size() != 0 || out_valid); i++) step(1);
    chk("drain_empty", q.size(), 0);
  endtask

  // Monitor: compares every presented result against the scoreboard head.
  exp_t         e_pop;
  int           acc;
  logic [N-1:0] last_diff = '0;
  logic         last_bout = 1'b0;
  logic         last_ovf = 1'b0;
  bit           was_valid = 1'b0;
  bit           hs_prev = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      acc_q.delete();
      last_diff = '0;
      last_bout = 1'b0;
      last_ovf  = 1'b0;
      was_valid = 1'b0;
      hs_prev   = 1'b0;
    end else begin
      if (hs_prev) chk("ready_after_hs", 32'(in_ready), 1);
      if (out_valid) begin
        chk("ready_low_done", 32'(in_ready), 0);
        if (!was_valid) begin
          chk("acc_pending", 32'(acc_q.size() != 0), 1);
          if (acc_q.size() != 0) begin
            acc = acc_q.pop_front();
            chk("latency", 32'(cyc - acc), N);
          end
        end
        chk("q_nonempty", 32'(q.size() != 0), 1);
        if (q.size() != 0) begin
          chk("diff", 32'(diff), 32'(q[0].diff));
          chk("bout", 32'(bout), 32'(q[0].bout));
`ifdef SERIAL_SUB_OVF_EN
          chk("ovf", 32'(ovf), 32'(q[0].ovf));
`endif
          if (out_ready) begin
            e_pop     = q.pop_front();
            last_diff = e_pop.diff;
            last_bout = e_pop.bout;
            last_ovf  = e_pop.ovf;
          end
        end
      end else begin
        chk("diff_hold", 32'(diff), 32'(last_diff));
        chk("bout_hold", 32'(bout), 32'(last_bout));
`ifdef SERIAL_SUB_OVF_EN
        chk("ovf_hold", 32'(ovf), 32'(last_ovf));
`endif
      end
      was_valid = out_valid && !out_ready;
      hs_prev   = out_valid && out_ready;
    end
  end

  initial begin
    bit seen;
    step(3);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_diff", 32'(diff), 0);
    chk("rst_bout", 32'(bout), 0);
`ifdef SERIAL_SUB_OVF_EN
    chk("rst_ovf", 32'(ovf), 0);
`endif
    @(posedge clk);
    #2;
    rst = 1'b0;

    // Directed corner values
    out_ready = 1'b1;
    issue(8'h05, 8'h03, 1'b0);
    issue(8'h00, 8'h01, 1'b0);
    issue(8'hFF, 8'hFF, 1'b1);
    drain();

    // Consumer stalls in DONE while in_valid is pulsed
    out_ready = 1'b0;
    issue(8'hA5, 8'h3C, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("stall_valid_seen", 32'(seen), 1);
    repeat (5) begin
      @(posedge clk);
      #2;
      in_valid = 1'b1;
      a = N'($urandom);
      b = N'($urandom);
      bin = 1'($urandom);
      @(negedge clk);
      chk("stall_out_valid", 32'(out_valid), 1);
    end
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    drain();

    // Reset mid-RUN drops the operation
    issue(8'h33, 8'h11, 1'b0);
    step(2);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", 32'(in_ready), 1);
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_diff", 32'(diff), 0);
    chk("midrst_bout", 32'(bout), 0);
    @(posedge clk);
    #2;
    issue(8'h10, 8'h01, 1'b0);
    drain();

`ifdef SERIAL_SUB_OVF_EN
    issue(8'h80, 8'h01, 1'b0);
    issue(8'h7F, 8'hFF, 1'b0);
    issue(8'h05, 8'h03, 1'b0);
    drain();
`endif

    // Back-to-back with consumer always ready
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) issue(N'($urandom), N'($urandom), 1'($urandom));
    drain();

    // Random operands with random consumer backpressure
    rnd = 1'b1;
    for (int i = 0; i < 40; i++) issue(N'($urandom), N'($urandom), 1'($urandom));
    rnd = 1'b0;
    drain();
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
